// File: rtl/bcd_scan_counter_pkg.sv
// Shared constants and helpers for the two-digit BCD scan counter.
// Digit-select codes, the blank code and terminal-count digit split live here.
package bcd_scan_counter_pkg;

   localparam logic [1:0] DIG_ONES   = 2'b01;
   localparam logic [1:0] DIG_TENS   = 2'b10;
   localparam logic [3:0] BLANK_CODE = 4'hF;
   localparam logic [3:0] BCD_MAX    = 4'd9;

   function automatic logic [3:0] max_tens(input int unsigned v);
      return 4'(v / 10);
   endfunction

   function automatic logic [3:0] max_ones(input int unsigned v);
      return 4'(v % 10);
   endfunction

endpackage

// File: rtl/bcd_scan_counter_if.sv
// Control and display bus of the BCD scan counter.
// The master side drives the controls; the counter (slave) drives digits and scan.
interface bcd_scan_counter_if;

   logic       ena;
   logic       run;
   logic       up_dn;
   logic       clr;
   logic       load;
   logic [7:0] load_val;
   logic [3:0] ones;
   logic [3:0] tens;
   logic       wrap;
   logic [3:0] val;
   logic [1:0] dig_sel;

   modport master (
      output ena, run, up_dn, clr, load, load_val,
      input  ones, tens, wrap, val, dig_sel
   );

   modport slave (
      input  ena, run, up_dn, clr, load, load_val,
      output ones, tens, wrap, val, dig_sel
   );

endinterface

// File: rtl/bcd_scan_counter_tick_gen.sv
// Modulo-DIV prescaler: tick is high while enabled on the last count of the period,
// and the counter wraps to zero on that same edge.
module tick_gen #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic sync_clr,
   output logic tick
);

   localparam int            CW   = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (sync_clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
   end

   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/bcd_scan_counter.sv
// Two-digit BCD up/down counter with prescaler and a two-slot display scan.
// val is computed from next-state count and next-state dig_sel so both change together.
module bcd_scan_counter
   import bcd_scan_counter_pkg::*;
#(
   parameter int CLK_DIV  = 1000000,
   parameter int SCAN_DIV = 1000,
   parameter int MAX_VAL  = 99,
   parameter int BLANK_LZ = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   bcd_scan_counter_if.slave    bus
);

   localparam logic [3:0] MAX_T = max_tens(MAX_VAL);
   localparam logic [3:0] MAX_O = max_ones(MAX_VAL);

   logic [3:0] ones_q, tens_q, val_q;
   logic [3:0] ones_d, tens_d, val_d;
   logic [1:0] dig_q, dig_d;
   logic       wrap_q, wrap_d;
   logic       cnt_tick, scan_tick;
   logic [3:0] lv_t, lv_o;

   // A load or clear restarts the count period; ena=0 freezes everything.
   tick_gen #(.DIV(CLK_DIV)) u_cnt_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (bus.ena & bus.run),
      .sync_clr (bus.ena & (bus.clr | bus.load)),
      .tick     (cnt_tick)
   );

   tick_gen #(.DIV(SCAN_DIV)) u_scan_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (bus.ena),
      .sync_clr (1'b0),
      .tick     (scan_tick)
   );

   assign lv_t = bus.load_val[7:4];
   assign lv_o = bus.load_val[3:0];

   always_comb begin
      ones_d = ones_q;
      tens_d = tens_q;
      wrap_d = 1'b0;
      if (bus.clr) begin
         ones_d = 4'd0;
         tens_d = 4'd0;
      end else if (bus.load) begin
         // Non-BCD nibbles leave the count alone; oversize values clamp.
         if (lv_t <= BCD_MAX && lv_o <= BCD_MAX) begin
            if (lv_t > MAX_T || (lv_t == MAX_T && lv_o > MAX_O)) begin
               ones_d = MAX_O;
               tens_d = MAX_T;
            end else begin
               ones_d = lv_o;
               tens_d = lv_t;
            end
         end
      end else if (cnt_tick) begin
         if (bus.up_dn) begin
            if (ones_q == MAX_O && tens_q == MAX_T) begin
               ones_d = 4'd0;
               tens_d = 4'd0;
               wrap_d = 1'b1;
            end else if (ones_q == BCD_MAX) begin
               ones_d = 4'd0;
               tens_d = tens_q + 4'd1;
            end else begin
               ones_d = ones_q + 4'd1;
            end
         end else begin
            if (ones_q == 4'd0 && tens_q == 4'd0) begin
               ones_d = MAX_O;
               tens_d = MAX_T;
               wrap_d = 1'b1;
            end else if (ones_q == 4'd0) begin
               ones_d = BCD_MAX;
               tens_d = tens_q - 4'd1;
            end else begin
               ones_d = ones_q - 4'd1;
            end
         end
      end
   end

   always_comb begin
      dig_d = scan_tick ? {dig_q[0], dig_q[1]} : dig_q;
      if (dig_d == DIG_ONES) begin
         val_d = ones_d;
      end else if (BLANK_LZ != 0 && tens_d == 4'd0) begin
         val_d = BLANK_CODE;
      end else begin
         val_d = tens_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ones_q <= 4'd0;
         tens_q <= 4'd0;
         wrap_q <= 1'b0;
         val_q  <= 4'd0;
         dig_q  <= DIG_ONES;
      end else if (bus.ena) begin
         ones_q <= ones_d;
         tens_q <= tens_d;
         wrap_q <= wrap_d;
         val_q  <= val_d;
         dig_q  <= dig_d;
      end else begin
         wrap_q <= 1'b0;
      end
   end

   assign bus.ones    = ones_q;
   assign bus.tens    = tens_q;
   assign bus.wrap    = wrap_q;
   assign bus.val     = val_q;
   assign bus.dig_sel = dig_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter with CLK_DIV=4, SCAN_DIV=3, MAX_VAL=12, BLANK_LZ=1.
// Edge numbers En count posedges after the first reset release; scan toggles on multiples of 3.
module tb_bcd_scan_counter;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   bcd_scan_counter_if bus ();

   bcd_scan_counter #(
      .CLK_DIV  (4),
      .SCAN_DIV (3),
      .MAX_VAL  (12),
      .BLANK_LZ (1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_count(input string tag, input logic [7:0] exp);
      tests++;
      assert ({bus.tens, bus.ones} === exp)
      else begin
         fails++;
         $error("FAIL %s: count observed %h expected %h", tag, {bus.tens, bus.ones}, exp);
      end
   endtask

   task automatic chk_scan(input string tag, input logic [1:0] d, input logic [3:0] v);
      tests++;
      assert ({bus.dig_sel, bus.val} === {d, v})
      else begin
         fails++;
         $error("FAIL %s: dig_sel/val observed %b/%h expected %b/%h",
                tag, bus.dig_sel, bus.val, d, v);
      end
   endtask

   task automatic chk_wrap(input string tag, input logic w);
      tests++;
      assert (bus.wrap === w)
      else begin
         fails++;
         $error("FAIL %s: wrap observed %b expected %b", tag, bus.wrap, w);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n        = 1'b0;
      bus.ena      = 1'b0;
      bus.run      = 1'b0;
      bus.up_dn    = 1'b0;
      bus.clr      = 1'b0;
      bus.load     = 1'b0;
      bus.load_val = 8'h00;

      step(1);
      chk_count("reset_count", 8'h00);
      chk_wrap ("reset_wrap", 1'b0);
      chk_scan ("reset_scan", 2'b01, 4'h0);

      // Release and count up.
      rst_n = 1'b1; bus.ena = 1'b1; bus.run = 1'b1; bus.up_dn = 1'b1;
      step(3);                                   // E3
      chk_count("up_before_tick", 8'h00);
      chk_scan ("scan_first_toggle", 2'b10, 4'hF);
      step(1);                                   // E4
      chk_count("up_first_tick", 8'h01);
      chk_scan ("scan_tens_blank", 2'b10, 4'hF);
      step(35);                                  // E39
      chk_count("up_09", 8'h09);
      step(1);                                   // E40
      chk_count("up_carry_10", 8'h10);
      chk_scan ("scan_tens_1", 2'b10, 4'h1);
      step(11);                                  // E51
      chk_count("up_12", 8'h12);
      chk_wrap ("up_no_wrap_yet", 1'b0);
      step(1);                                   // E52
      chk_count("up_wrap_00", 8'h00);
      chk_wrap ("up_wrap_pulse", 1'b1);
      chk_scan ("scan_blank_00", 2'b10, 4'hF);
      step(1);                                   // E53
      chk_wrap ("up_wrap_one_cycle", 1'b0);

      // Count down.
      bus.up_dn = 1'b0;
      step(3);                                   // E56
      chk_count("dn_wrap_12", 8'h12);
      chk_wrap ("dn_wrap_pulse", 1'b1);
      chk_scan ("scan_ones_2", 2'b01, 4'h2);
      step(4);                                   // E60
      chk_count("dn_11", 8'h11);
      chk_wrap ("dn_wrap_cleared", 1'b0);
      chk_scan ("scan_11_ones", 2'b01, 4'h1);
      step(3);                                   // E63
      chk_scan ("scan_11_tens", 2'b10, 4'h1);
      step(5);                                   // E68
      chk_count("dn_borrow_09", 8'h09);
      chk_scan ("scan_ones_9", 2'b01, 4'h9);

      // Loads and clear.
      bus.load = 1'b1; bus.load_val = 8'h07;
      step(1);                                   // E69
      bus.load = 1'b0;
      chk_count("load_07", 8'h07);
      chk_wrap ("load_no_wrap", 1'b0);
      chk_scan ("scan_07_tens_blank", 2'b10, 4'hF);
      step(3);                                   // E72
      chk_count("load_restart_hold", 8'h07);
      step(1);                                   // E73
      chk_count("load_restart_tick", 8'h06);
      bus.load = 1'b1; bus.load_val = 8'h45;
      step(1);                                   // E74
      chk_count("load_clamp", 8'h12);
      bus.load_val = 8'h1A;
      step(1);                                   // E75
      chk_count("load_nonbcd_ignored", 8'h12);
      bus.clr = 1'b1; bus.load_val = 8'h07;
      step(1);                                   // E76
      chk_count("clr_over_load", 8'h00);
      bus.clr = 1'b0; bus.load = 1'b0;

      // Freeze with ena=0 mid-period (count phase 1, scan phase 2).
      step(1);                                   // E77
      bus.ena = 1'b0;
      step(10);
      chk_count("ena0_count_held", 8'h00);
      chk_scan ("ena0_scan_held", 2'b10, 4'hF);
      bus.ena = 1'b1;
      step(1);                                   // equiv E78
      chk_scan ("ena1_scan_phase", 2'b01, 4'h0);
      step(1);                                   // equiv E79
      chk_count("ena1_count_phase_hold", 8'h00);
      step(1);                                   // equiv E80
      chk_count("ena1_count_phase_tick", 8'h12);
      chk_wrap ("ena1_wrap", 1'b1);
      chk_scan ("ena1_scan_val", 2'b01, 4'h2);
      bus.ena = 1'b0;
      step(1);
      chk_wrap ("ena0_forces_wrap_low", 1'b0);
      chk_count("ena0_hold_12", 8'h12);
      chk_scan ("ena0_hold_scan", 2'b01, 4'h2);
      bus.ena = 1'b1;

      // run=0 holds the count prescaler while scan keeps going.
      step(1);                                   // equiv E81, count phase 1
      bus.run = 1'b0;
      step(8);                                   // scan equiv E89
      chk_count("run0_held", 8'h12);
      chk_scan ("run0_scan_moves", 2'b10, 4'h1);
      bus.run = 1'b1;
      step(2);
      chk_count("run1_phase_kept", 8'h12);
      step(1);
      chk_count("run1_tick", 8'h11);

      // Asynchronous reset between edges.
      #2 rst_n = 1'b0;
      #1;
      chk_count("async_rst_count", 8'h00);
      chk_wrap ("async_rst_wrap", 1'b0);
      chk_scan ("async_rst_scan", 2'b01, 4'h0);
      step(1);
      rst_n = 1'b1; bus.up_dn = 1'b1;
      step(3);
      chk_count("post_rst_no_tick", 8'h00);
      chk_scan ("post_rst_scan", 2'b10, 4'hF);
      step(1);
      chk_count("post_rst_first_tick", 8'h01);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
